// File: rtl/pipe_control_unit_if.sv
// Decode-to-execute control bundle interface for pipe_control_unit.
// The master drives the decode-side request and pipeline controls;
// the slave (the control unit) returns the registered control bundle.
interface pipe_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic [3:0]       opcode;
    logic [1:0]       mode;
    logic             s_in;
    logic             cond_pass;
    logic             stall;
    logic             flush;
    logic             ready_out;
    logic             valid_out;
    logic [3:0]       exe_cmd;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output valid_in, opcode, mode, s_in, cond_pass, stall, flush,
        input  ready_out, valid_out, exe_cmd, wb_en, mem_r_en, mem_w_en,
               b, s, busy, op_count
    );

    modport slave (
        input  valid_in, opcode, mode, s_in, cond_pass, stall, flush,
        output ready_out, valid_out, exe_cmd, wb_en, mem_r_en, mem_w_en,
               b, s, busy, op_count
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipeline control unit: decodes the instruction at decode, registers the
// execute-stage control bundle, and sequences multi-cycle multiplies
// through a two-state IDLE/MUL machine. Also counts issued operations.
module pipe_control_unit #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_control_unit_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] CMD_MUL  = 4'b1010;
    localparam logic [3:0] CMD_ADD  = 4'b0010;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             mul_s_reg, mul_s_next;
    logic             valid_reg, valid_next;
    logic [3:0]       exe_cmd_reg, exe_cmd_next;
    logic             wb_reg, wb_next;
    logic             mem_r_reg, mem_r_next;
    logic             mem_w_reg, mem_w_next;
    logic             b_reg, b_next;
    logic             s_reg, s_next;
    logic [CNT_W-1:0] op_count_reg, op_count_next;

    logic [3:0] dec_cmd;
    logic       dec_wb, dec_mem_r, dec_mem_w, dec_b, dec_s;
    logic       ready, accept, mul_go;

    // Instruction decode; enables are squashed when the condition fails.
    always_comb begin
        dec_cmd   = 4'b0000;
        dec_wb    = 1'b0;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        case (bus.mode)
            2'b00: begin
                dec_s = bus.s_in;
                case (bus.opcode)
                    4'b1101: begin dec_cmd = 4'b0001; dec_wb = 1'b1; end // MOV
                    4'b1111: begin dec_cmd = 4'b1001; dec_wb = 1'b1; end // MVN
                    4'b0100: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end // ADD
                    4'b0101: begin dec_cmd = 4'b0011; dec_wb = 1'b1; end // ADC
                    4'b0010: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end // SUB
                    4'b0110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end // SBC
                    4'b0000: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end // AND
                    4'b1100: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end // ORR
                    4'b0001: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end // EOR
                    4'b1010: dec_cmd = 4'b0100;                         // CMP
                    4'b1000: dec_cmd = 4'b0110;                         // TST
                    default: dec_cmd = 4'b0000;
                endcase
            end
            2'b01: begin
                dec_cmd = CMD_ADD;
                if (bus.s_in) begin
                    dec_mem_r = 1'b1;
                    dec_wb    = 1'b1;
                end else begin
                    dec_mem_w = 1'b1;
                end
            end
            2'b10: dec_b = 1'b1;
            default: begin
                dec_cmd = CMD_MUL;
                dec_wb  = 1'b1;
                dec_s   = bus.s_in;
            end
        endcase
        if (!bus.cond_pass) begin
            dec_wb    = 1'b0;
            dec_mem_r = 1'b0;
            dec_mem_w = 1'b0;
            dec_b     = 1'b0;
            dec_s     = 1'b0;
        end
    end

    // Handshake: accept only in IDLE with the pipe free and out of reset.
    always_comb begin
        ready  = (state_reg == IDLE) && !bus.stall && !bus.flush && rst_n;
        accept = ready && bus.valid_in;
        // A failed-condition multiply has nothing to compute, so it skips MUL.
        mul_go = accept && (bus.mode == 2'b11) && bus.cond_pass && (MUL_CYCLES > 1);
    end

    // Next-state and next-bundle selection: flush > stall > accept/MUL progress.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mul_s_next    = mul_s_reg;
        valid_next    = valid_reg;
        exe_cmd_next  = exe_cmd_reg;
        wb_next       = wb_reg;
        mem_r_next    = mem_r_reg;
        mem_w_next    = mem_w_reg;
        b_next        = b_reg;
        s_next        = s_reg;
        op_count_next = op_count_reg;

        if (bus.flush) begin
            state_next   = IDLE;
            cnt_next     = 4'd0;
            valid_next   = 1'b0;
            exe_cmd_next = 4'b0000;
            wb_next      = 1'b0;
            mem_r_next   = 1'b0;
            mem_w_next   = 1'b0;
            b_next       = 1'b0;
            s_next       = 1'b0;
        end else if (!bus.stall) begin
            // Bubble unless something below loads a real bundle.
            valid_next   = 1'b0;
            exe_cmd_next = 4'b0000;
            wb_next      = 1'b0;
            mem_r_next   = 1'b0;
            mem_w_next   = 1'b0;
            b_next       = 1'b0;
            s_next       = 1'b0;
            if (state_reg == IDLE) begin
                if (mul_go) begin
                    state_next = MUL;
                    cnt_next   = MUL_LOAD;
                    mul_s_next = bus.s_in;
                end else if (accept) begin
                    valid_next    = 1'b1;
                    exe_cmd_next  = dec_cmd;
                    wb_next       = dec_wb;
                    mem_r_next    = dec_mem_r;
                    mem_w_next    = dec_mem_w;
                    b_next        = dec_b;
                    s_next        = dec_s;
                    op_count_next = op_count_reg + 1'b1;
                end
            end else begin
                cnt_next = cnt_reg - 4'd1;
                // Counter about to reach zero: this edge delivers the result.
                if (cnt_reg == 4'd1) begin
                    state_next    = IDLE;
                    cnt_next      = 4'd0;
                    valid_next    = 1'b1;
                    exe_cmd_next  = CMD_MUL;
                    wb_next       = 1'b1;
                    s_next        = mul_s_reg;
                    op_count_next = op_count_reg + 1'b1;
                end
            end
        end
    end

    // State, counter and control bundle registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            mul_s_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            exe_cmd_reg  <= 4'b0000;
            wb_reg       <= 1'b0;
            mem_r_reg    <= 1'b0;
            mem_w_reg    <= 1'b0;
            b_reg        <= 1'b0;
            s_reg        <= 1'b0;
            op_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mul_s_reg    <= mul_s_next;
            valid_reg    <= valid_next;
            exe_cmd_reg  <= exe_cmd_next;
            wb_reg       <= wb_next;
            mem_r_reg    <= mem_r_next;
            mem_w_reg    <= mem_w_next;
            b_reg        <= b_next;
            s_reg        <= s_next;
            op_count_reg <= op_count_next;
        end
    end

    assign bus.ready_out = ready;
    assign bus.valid_out = valid_reg;
    assign bus.exe_cmd   = exe_cmd_reg;
    assign bus.wb_en     = wb_reg;
    assign bus.mem_r_en  = mem_r_reg;
    assign bus.mem_w_en  = mem_w_reg;
    assign bus.b         = b_reg;
    assign bus.s         = s_reg;
    assign bus.busy      = (state_reg == MUL);
    assign bus.op_count  = op_count_reg;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: a table of single-cycle decode
// vectors plus hand-written multi-cycle sequences (multiply, stall, flush,
// reset, counter wrap). A second instance with MUL_CYCLES=1 shares stimulus.
module tb_pipe_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_control_unit_if #(.CNT_W(4)) bus ();
    pipe_control_unit_if #(.CNT_W(4)) bus1 ();

    assign bus1.valid_in  = bus.valid_in;
    assign bus1.opcode    = bus.opcode;
    assign bus1.mode      = bus.mode;
    assign bus1.s_in      = bus.s_in;
    assign bus1.cond_pass = bus.cond_pass;
    assign bus1.stall     = bus.stall;
    assign bus1.flush     = bus.flush;

    pipe_control_unit #(.MUL_CYCLES(3), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_control_unit #(.MUL_CYCLES(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // {valid, cmd, wb, mem_r, mem_w, b, s, busy}
    typedef struct packed {
        logic       vin;
        logic [3:0] op;
        logic [1:0] md;
        logic       sin;
        logic       cp;
        logic [10:0] exp;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_cnt;
    vec_t vecs [19];

    function automatic logic [10:0] bnd(logic v, logic [3:0] c, logic wb, logic mr,
                                        logic mw, logic bb, logic ss, logic bz);
        return {v, c, wb, mr, mw, bb, ss, bz};
    endfunction

    function automatic logic [10:0] obs0();
        return {bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en,
                bus.b, bus.s, bus.busy};
    endfunction

    function automatic logic [10:0] obs1();
        return {bus1.valid_out, bus1.exe_cmd, bus1.wb_en, bus1.mem_r_en, bus1.mem_w_en,
                bus1.b, bus1.s, bus1.busy};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic vin, logic [3:0] op, logic [1:0] md, logic sin, logic cp);
        bus.valid_in  = vin;
        bus.opcode    = op;
        bus.mode      = md;
        bus.s_in      = sin;
        bus.cond_pass = cp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] ZERO  = 11'b0;
    localparam logic [10:0] BUSY  = 11'b00000000001;

    initial begin
        vecs[0]  = '{1'b1, 4'b0100, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0010, 1, 0, 0, 0, 1, 0)}; // ADD
        vecs[1]  = '{1'b1, 4'b1101, 2'b00, 1'b0, 1'b1, bnd(1, 4'b0001, 1, 0, 0, 0, 0, 0)}; // MOV
        vecs[2]  = '{1'b1, 4'b1111, 2'b00, 1'b1, 1'b1, bnd(1, 4'b1001, 1, 0, 0, 0, 1, 0)}; // MVN
        vecs[3]  = '{1'b1, 4'b0101, 2'b00, 1'b0, 1'b1, bnd(1, 4'b0011, 1, 0, 0, 0, 0, 0)}; // ADC
        vecs[4]  = '{1'b1, 4'b0010, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0100, 1, 0, 0, 0, 1, 0)}; // SUB
        vecs[5]  = '{1'b1, 4'b0110, 2'b00, 1'b0, 1'b1, bnd(1, 4'b0101, 1, 0, 0, 0, 0, 0)}; // SBC
        vecs[6]  = '{1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, bnd(1, 4'b0110, 1, 0, 0, 0, 0, 0)}; // AND
        vecs[7]  = '{1'b1, 4'b1100, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0111, 1, 0, 0, 0, 1, 0)}; // ORR
        vecs[8]  = '{1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, bnd(1, 4'b1000, 1, 0, 0, 0, 0, 0)}; // EOR
        vecs[9]  = '{1'b1, 4'b1010, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0100, 0, 0, 0, 0, 1, 0)}; // CMP
        vecs[10] = '{1'b1, 4'b1000, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0110, 0, 0, 0, 0, 1, 0)}; // TST
        vecs[11] = '{1'b1, 4'b0011, 2'b00, 1'b1, 1'b1, bnd(1, 4'b0000, 0, 0, 0, 0, 1, 0)}; // undefined
        vecs[12] = '{1'b1, 4'b0000, 2'b01, 1'b0, 1'b1, bnd(1, 4'b0010, 0, 0, 1, 0, 0, 0)}; // store
        vecs[13] = '{1'b1, 4'b0000, 2'b01, 1'b1, 1'b1, bnd(1, 4'b0010, 1, 1, 0, 0, 0, 0)}; // load
        vecs[14] = '{1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, bnd(1, 4'b0000, 0, 0, 0, 1, 0, 0)}; // branch
        vecs[15] = '{1'b1, 4'b1010, 2'b00, 1'b1, 1'b0, bnd(1, 4'b0100, 0, 0, 0, 0, 0, 0)}; // CMP cond fail
        vecs[16] = '{1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, bnd(1, 4'b1010, 0, 0, 0, 0, 0, 0)}; // MUL cond fail
        vecs[17] = '{1'b0, 4'b0100, 2'b00, 1'b1, 1'b1, ZERO};                             // bubble
        vecs[18] = '{1'b1, 4'b0100, 2'b00, 1'b1, 1'b0, bnd(1, 4'b0010, 0, 0, 0, 0, 0, 0)}; // ADD cond fail

        // Reset: outputs zero, ready held low while rst_n=0.
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1, 4'b0100, 2'b00, 1, 1);
        step();
        step();
        check("reset_bundle", 32'(obs0()), 32'(ZERO));
        check("reset_count", 32'(bus.op_count), 0);
        check("reset_ready", 32'(bus.ready_out), 0);
        rst_n = 1'b1;
        drive(0, 4'b0000, 2'b00, 0, 1);
        #1;
        check("idle_ready", 32'(bus.ready_out), 1);
        step();
        check("idle_bubble", 32'(obs0()), 32'(ZERO));
        exp_cnt = 4'd0;

        // Table-driven single-cycle decodes.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].vin, vecs[i].op, vecs[i].md, vecs[i].sin, vecs[i].cp);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(bus.ready_out), 1);
            step();
            if (vecs[i].exp[10]) exp_cnt = exp_cnt + 4'd1;
            check($sformatf("vec%0d_bundle", i), 32'(obs0()), 32'(vecs[i].exp));
            check($sformatf("vec%0d_count", i), 32'(bus.op_count), 32'(exp_cnt));
            $display("[TB] vec %0d mode=%b op=%b s_in=%b cp=%b -> bundle=%b count=%0d",
                     i, vecs[i].md, vecs[i].op, vecs[i].sin, vecs[i].cp, obs0(), bus.op_count);
        end

        // Multiply, MUL_CYCLES=3; an ADD offered while busy must be ignored.
        drive(1, 4'b0000, 2'b11, 1, 1);
        step();
        check("mul1_short", 32'(obs1()), 32'(bnd(1, 4'b1010, 1, 0, 0, 0, 1, 0)));
        check("mul_c1", 32'(obs0()), 32'(BUSY));
        drive(1, 4'b0100, 2'b00, 1, 1);
        #1;
        check("mul_c1_ready", 32'(bus.ready_out), 0);
        step();
        check("mul_c2", 32'(obs0()), 32'(BUSY));
        check("mul_c2_ready", 32'(bus.ready_out), 0);
        step();
        exp_cnt = exp_cnt + 4'd1;
        check("mul_c3", 32'(obs0()), 32'(bnd(1, 4'b1010, 1, 0, 0, 0, 1, 0)));
        check("mul_c3_count", 32'(bus.op_count), 32'(exp_cnt));
        drive(0, 4'b0000, 2'b00, 0, 1);
        step();
        check("mul_after", 32'(obs0()), 32'(ZERO));
        $display("[TB] mul basic done count=%0d", bus.op_count);

        // Stall 2 cycles mid-multiply, then stall holding a valid result.
        drive(1, 4'b0000, 2'b11, 0, 1);
        step();
        drive(0, 4'b0000, 2'b00, 0, 1);
        bus.stall = 1'b1;
        #1;
        check("stall_ready", 32'(bus.ready_out), 0);
        step();
        check("stall_c2", 32'(obs0()), 32'(BUSY));
        step();
        check("stall_c3", 32'(obs0()), 32'(BUSY));
        bus.stall = 1'b0;
        step();
        check("stall_c4", 32'(obs0()), 32'(BUSY));
        step();
        exp_cnt = exp_cnt + 4'd1;
        check("stall_c5", 32'(obs0()), 32'(bnd(1, 4'b1010, 1, 0, 0, 0, 0, 0)));
        bus.stall = 1'b1;
        step();
        check("stall_hold", 32'(obs0()), 32'(bnd(1, 4'b1010, 1, 0, 0, 0, 0, 0)));
        check("stall_hold_count", 32'(bus.op_count), 32'(exp_cnt));
        bus.stall = 1'b0;
        step();
        check("stall_release", 32'(obs0()), 32'(ZERO));
        $display("[TB] mul stall done count=%0d", bus.op_count);

        // Flush aborts a multiply; flush beats stall on a valid bundle.
        drive(1, 4'b0000, 2'b11, 1, 1);
        step();
        drive(0, 4'b0000, 2'b00, 0, 1);
        bus.flush = 1'b1;
        step();
        check("flush_mul", 32'(obs0()), 32'(ZERO));
        bus.flush = 1'b0;
        step();
        step();
        check("flush_no_late", 32'(obs0()), 32'(ZERO));
        check("flush_count", 32'(bus.op_count), 32'(exp_cnt));
        drive(1, 4'b0100, 2'b00, 1, 1);
        step();
        exp_cnt = exp_cnt + 4'd1;
        check("flush_add", 32'(obs0()), 32'(bnd(1, 4'b0010, 1, 0, 0, 0, 1, 0)));
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("flush_ready", 32'(bus.ready_out), 0);
        step();
        check("flush_over_stall", 32'(obs0()), 32'(ZERO));
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(0, 4'b0000, 2'b00, 0, 1);
        $display("[TB] flush done count=%0d", bus.op_count);

        // Reset during multiply discards it.
        drive(1, 4'b0000, 2'b11, 1, 1);
        step();
        rst_n = 1'b0;
        drive(0, 4'b0000, 2'b00, 0, 1);
        step();
        check("rst_mul_bundle", 32'(obs0()), 32'(ZERO));
        check("rst_mul_count", 32'(bus.op_count), 0);
        exp_cnt = 4'd0;
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst_mul_no_late", 32'(obs0()), 32'(ZERO));
        $display("[TB] reset during mul done");

        // 16 back-to-back ADDs wrap the 4-bit counter to 0.
        drive(1, 4'b0100, 2'b00, 0, 1);
        for (int k = 0; k < 16; k++) begin
            step();
            exp_cnt = exp_cnt + 4'd1;
            if (k == 14) check("wrap_15", 32'(bus.op_count), 15);
        end
        check("wrap_0", 32'(bus.op_count), 32'(exp_cnt));
        check("wrap_zero", 32'(bus.op_count), 0);
        drive(0, 4'b0000, 2'b00, 0, 1);
        $display("[TB] wrap done count=%0d", bus.op_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
